// File: rtl/max_pool_2x2_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pool stage.
// Holds pixel width default, map counter width, FSM state enum and a signed-compare helper.
package max_pool_2x2_pkg;

  localparam int POOL_DW    = 16;
  localparam int POOL_MAX_W = 512;
  localparam int CNT_W      = 9;

  typedef enum logic [1:0] {
    IDLE,
    EVEN_ROW,
    ODD_ROW
  } state_t;

  // Width-generic signed greater-than: callers sign-extend into 64 bits.
  function automatic logic sgt(
    input logic signed [63:0] a,
    input logic signed [63:0] b
  );
    return a > b;
  endfunction

endpackage

// File: rtl/max_pool_2x2_if.sv
// Pixel stream bundle between the convolution stage, the pool stage and its consumer.
// master drives map_size/pi_*, slave (the pool stage) drives po_* and frame_done.
interface max_pool_2x2_if
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W = POOL_DW
);

  logic [CNT_W-1:0]         map_size;
  logic                     pi_data_valid;
  logic signed [DATA_W-1:0] pi_data;
  logic signed [DATA_W-1:0] po_data;
  logic                     po_data_valid;
  logic                     frame_done;

  modport master (
    output map_size,
    output pi_data_valid,
    output pi_data,
    input  po_data,
    input  po_data_valid,
    input  frame_done
  );

  modport slave (
    input  map_size,
    input  pi_data_valid,
    input  pi_data,
    output po_data,
    output po_data_valid,
    output frame_done
  );

endinterface

// File: rtl/max_pool_2x2_line_buf.sv
// Half-width line buffer: one write port, one synchronous read port, no reset (block RAM).
// Ports: clk, we/waddr/wdata write side, re/raddr read side, rdata held until next read.
module max_pool_2x2_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 max pool over a raster pixel stream, optional ReLU on each pooled pixel.
// Ports: sys_clk, sys_rst (sync, active high), bus (slave: map_size, pi_*, po_*, frame_done).
module max_pool_2x2
  import max_pool_2x2_pkg::*;
#(
  parameter int DATA_W  = POOL_DW,
  parameter int MAX_W   = POOL_MAX_W,
  parameter bit RELU_EN = 1'b1
) (
  input logic            sys_clk,
  input logic            sys_rst,
  max_pool_2x2_if.slave  bus
);

  localparam int DEPTH = MAX_W / 2;
  localparam int AW    = $clog2(DEPTH);

  state_t                   state;
  logic [CNT_W-1:0]         col;
  logic [CNT_W-1:0]         row;
  logic [CNT_W-1:0]         size;
  logic signed [DATA_W-1:0] hreg;
  logic signed [DATA_W-1:0] po_q;
  logic                     po_valid_q;
  logic                     done_q;

  logic [CNT_W-1:0]         cur_size;
  logic                     accept;
  logic                     odd_row;
  logic                     odd_col;
  logic                     last_col;
  logic                     last_row;
  logic                     we;
  logic                     re;
  logic                     out_en;
  logic [AW-1:0]            addr;
  logic signed [DATA_W-1:0] h;
  logic signed [DATA_W-1:0] lb_word;
  logic signed [DATA_W-1:0] pool;

  // In IDLE the incoming beat is pixel (0,0): use the live map_size.
  always_comb begin
    cur_size = (state == IDLE) ? bus.map_size : size;
    accept   = bus.pi_data_valid
             && ((state != IDLE) || (bus.map_size >= CNT_W'(2)));
    odd_row  = (state == ODD_ROW);
    odd_col  = col[0];
    last_col = (col == cur_size - CNT_W'(1));
    last_row = (row == cur_size - CNT_W'(1));
    we       = accept && !odd_row && odd_col;
    re       = accept && odd_row && !odd_col;
    out_en   = accept && odd_row && odd_col;
    addr     = col[AW:1];
  end

  always_comb begin
    h = sgt(64'(bus.pi_data), 64'(hreg))
      ? bus.pi_data : hreg;
    pool = sgt(64'(lb_word), 64'(h))
      ? lb_word : h;
  end

  // Read issued on the even column so the word is ready for the odd one.
  max_pool_2x2_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_line_buf (
    .clk    (sys_clk),
    .we     (we),
    .waddr  (addr),
    .wdata  (h),
    .re     (re),
    .raddr  (addr),
    .rdata  (lb_word)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      size       <= '0;
      hreg       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      po_valid_q <= out_en;
      done_q     <= 1'b0;
      if (out_en) begin
        if (RELU_EN && pool[DATA_W-1]) begin
          po_q <= '0;
        end else begin
          po_q <= pool;
        end
      end
      if (accept) begin
        if (!odd_col) begin
          hreg <= bus.pi_data;
        end
        if (state == IDLE) begin
          size <= bus.map_size;
        end
        if (last_col && last_row) begin
          state  <= IDLE;
          col    <= '0;
          row    <= '0;
          done_q <= 1'b1;
        end else if (last_col) begin
          col   <= '0;
          row   <= row + CNT_W'(1);
          state <= odd_row ? EVEN_ROW : ODD_ROW;
        end else begin
          col <= col + CNT_W'(1);
          if (state == IDLE) begin
            state <= EVEN_ROW;
          end
        end
      end
    end
  end

  assign bus.po_data       = po_q;
  assign bus.po_data_valid = po_valid_q;
  assign bus.frame_done    = done_q;

endmodule

// File: tb/tb_max_pool_2x2.sv
// Directed bench for max_pool_2x2: two instances (ReLU on / off) share one stimulus stream.
// Expected pooled values and contributing-beat indices are hand computed per vector.
module tb_max_pool_2x2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [8:0]        map_size = '0;
  logic              vld = 1'b0;
  logic signed [15:0] din = '0;

  always #5 clk = ~clk;

  max_pool_2x2_if #(.DATA_W(16)) if_r ();
  max_pool_2x2_if #(.DATA_W(16)) if_n ();

  assign if_r.map_size      = map_size;
  assign if_r.pi_data_valid = vld;
  assign if_r.pi_data       = din;
  assign if_n.map_size      = map_size;
  assign if_n.pi_data_valid = vld;
  assign if_n.pi_data       = din;

  max_pool_2x2 #(
    .DATA_W  (16),
    .MAX_W   (512),
    .RELU_EN (1'b1)
  ) u_relu (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (if_r)
  );

  max_pool_2x2 #(
    .DATA_W  (16),
    .MAX_W   (512),
    .RELU_EN (1'b0)
  ) u_raw (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (if_n)
  );

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int q_r[$];
  int q_n[$];
  int q_c[$];
  int d_c[$];
  int d_n = 0;
  int beat_c[$];

  int v1[4]  = '{5, 7, 13, 15};
  int vz[4]  = '{0, 0, 0, 0};
  int v2n[4] = '{-1, -3, -9, -11};
  int v3[4]  = '{6, 8, 16, 18};
  int v6[4]  = '{105, 107, 113, 115};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_r.po_data_valid) begin
      q_r.push_back(int'(if_r.po_data));
      q_c.push_back(cyc);
    end
    if (if_n.po_data_valid) q_n.push_back(int'(if_n.po_data));
    if (if_r.frame_done) d_c.push_back(cyc);
    if (if_n.frame_done) d_n = d_n + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int at(input int q[$], input int k);
    return (k < q.size()) ? q[k] : 32'h7fff_ffff;
  endfunction

  task automatic clr();
    q_r.delete();
    q_n.delete();
    q_c.delete();
    d_c.delete();
    beat_c.delete();
    d_n = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic beat(input int d);
    vld = 1'b1;
    din = 16'(d);
    @(negedge clk);
    beat_c.push_back(cyc);
    vld = 1'b0;
  endtask

  task automatic frame(input int sz, input int base, input int step,
                       input int maxgap, input int sz_after);
    map_size = 9'(sz);
    for (int i = 0; i < sz * sz; i++) begin
      if (maxgap > 0 && i > 0) idle(int'($urandom_range(maxgap, 1)));
      beat(base + step * i);
      if (i == 0) map_size = 9'(sz_after);
    end
  endtask

  // Pooled values for both instances plus strobe timing against the 4th beat.
  task automatic check_pool(input string tag, input int k0,
                            input int er[4], input int en[4],
                            input int bi[4], input int boff);
    for (int j = 0; j < 4; j++) begin
      check({tag, "_relu"}, at(q_r, k0 + j), er[j]);
      check({tag, "_raw"}, at(q_n, k0 + j), en[j]);
      check({tag, "_lat"}, at(q_c, k0 + j), at(beat_c, boff + bi[j]));
    end
  endtask

  initial begin
    idle(3);
    check("rst_po_data", int'(if_r.po_data), 0);
    check("rst_valid", int'(if_r.po_data_valid), 0);
    check("rst_done", int'(if_r.frame_done), 0);
    check("rst_raw_data", int'(if_n.po_data), 0);
    rst = 1'b0;
    idle(2);

    // map_size < 2 in IDLE: beats ignored
    clr();
    map_size = 9'd1;
    beat(7);
    beat(8);
    map_size = 9'd0;
    beat(9);
    idle(3);
    check("tiny_out", q_r.size(), 0);
    check("tiny_done", d_c.size(), 0);

    // case 1: 4x4 ramp, contiguous
    clr();
    frame(4, 0, 1, 0, 4);
    idle(3);
    check("c1_cnt", q_r.size(), 4);
    check("c1_cnt_raw", q_n.size(), 4);
    check_pool("c1", 0, v1, v1, v1, 0);
    check("c1_done_cnt", d_c.size(), 1);
    check("c1_done_cyc", at(d_c, 0), at(beat_c, 15));
    check("c1_done_raw", d_n, 1);

    // case 2: all negative
    clr();
    frame(4, -1, -1, 0, 4);
    idle(3);
    check("c2_cnt", q_r.size(), 4);
    check_pool("c2", 0, vz, v2n, v1, 0);

    // case 3: odd size 5, last col/row dropped
    clr();
    frame(5, 0, 1, 0, 5);
    idle(3);
    check("c3_cnt", q_r.size(), 4);
    check("c3_cnt_raw", q_n.size(), 4);
    check_pool("c3", 0, v3, v3, v3, 0);
    check("c3_done_cnt", d_c.size(), 1);
    check("c3_done_cyc", at(d_c, 0), at(beat_c, 24));

    // case 4: random gaps, map_size changed mid-frame
    clr();
    frame(4, 0, 1, 3, 6);
    idle(3);
    check("c4_cnt", q_r.size(), 4);
    check_pool("c4", 0, v1, v1, v1, 0);
    check("c4_done_cnt", d_c.size(), 1);
    check("c4_done_cyc", at(d_c, 0), at(beat_c, 15));

    // case 5: reset after beat 9 of a frame
    clr();
    map_size = 9'd4;
    for (int i = 0; i < 9; i++) beat(1000 + i);
    check("c5_pre_cnt", q_r.size(), 2);
    check("c5_pre_val", at(q_r, 1), 1007);
    check("c5_pre_done", d_c.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    check("c5_rst_data", int'(if_r.po_data), 0);
    check("c5_rst_valid", int'(if_r.po_data_valid), 0);
    rst = 1'b0;
    clr();
    frame(4, 0, 1, 0, 4);
    idle(3);
    check("c5_cnt", q_r.size(), 4);
    check_pool("c5", 0, v1, v1, v1, 0);
    check("c5_done_cnt", d_c.size(), 1);

    // case 6: back-to-back frames
    clr();
    frame(4, 0, 1, 0, 4);
    frame(4, 100, 1, 0, 4);
    idle(3);
    check("c6_cnt", q_r.size(), 8);
    check_pool("c6a", 0, v1, v1, v1, 0);
    check_pool("c6b", 4, v6, v6, v1, 16);
    check("c6_done_cnt", d_c.size(), 2);
    check("c6_done0", at(d_c, 0), at(beat_c, 15));
    check("c6_done1", at(d_c, 1), at(beat_c, 31));
    check("c6_done_raw", d_n, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
